// File: rtl/jtag_dtm.sv
// JTAG Debug Transport Module (RISC-V Debug 0.13).
// The JTAG pins are oversampled in the system clock domain. The module runs the TAP,
// the IR, the IDCODE/DTMCS/DMI/BYPASS data registers and the DMI initiator handshake.
module jtag_dtm #(
   parameter int unsigned AddressWidth = 7,
   parameter logic [31:0] IdCode       = 32'h1000_0A6F,
   parameter int unsigned SyncStages   = 2,
   parameter int unsigned IdleCycles   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tck,
   input  logic                    tms,
   input  logic                    tdi,
   output logic                    tdo,
   output logic                    tdo_oe,
   output logic                    dmi_req_valid,
   input  logic                    dmi_req_ready,
   output logic [AddressWidth-1:0] dmi_req_addr,
   output logic [31:0]             dmi_req_data,
   output logic [1:0]              dmi_req_op,
   input  logic                    dmi_rsp_valid,
   output logic                    dmi_rsp_ready,
   input  logic [31:0]             dmi_rsp_data,
   input  logic [1:0]              dmi_rsp_op
);

   localparam int unsigned DmiWidth = AddressWidth + 34;
   localparam int unsigned DrWidth  = (DmiWidth > 32) ? DmiWidth : 32;

   // IEEE 1149.1 TAP states
   localparam logic [3:0] TLR      = 4'd0;
   localparam logic [3:0] RTI      = 4'd1;
   localparam logic [3:0] SEL_DR   = 4'd2;
   localparam logic [3:0] CAP_DR   = 4'd3;
   localparam logic [3:0] SHIFT_DR = 4'd4;
   localparam logic [3:0] EXIT1_DR = 4'd5;
   localparam logic [3:0] PAUSE_DR = 4'd6;
   localparam logic [3:0] EXIT2_DR = 4'd7;
   localparam logic [3:0] UPD_DR   = 4'd8;
   localparam logic [3:0] SEL_IR   = 4'd9;
   localparam logic [3:0] CAP_IR   = 4'd10;
   localparam logic [3:0] SHIFT_IR = 4'd11;
   localparam logic [3:0] EXIT1_IR = 4'd12;
   localparam logic [3:0] PAUSE_IR = 4'd13;
   localparam logic [3:0] EXIT2_IR = 4'd14;
   localparam logic [3:0] UPD_IR   = 4'd15;

   localparam logic [4:0] IR_IDCODE = 5'h01;
   localparam logic [4:0] IR_DTMCS  = 5'h10;
   localparam logic [4:0] IR_DMI    = 5'h11;

   logic [SyncStages-1:0] tck_sync;
   logic [SyncStages-1:0] tms_sync;
   logic [SyncStages-1:0] tdi_sync;
   logic                  tck_q;
   logic                  tck_s;
   logic                  tms_s;
   logic                  tdi_s;
   logic                  tck_rise;
   logic                  tck_fall;

   logic [3:0]            tap_state;
   logic [4:0]            ir;
   logic [4:0]            ir_sr;
   logic [DrWidth-1:0]    dr_sr;
   logic [DrWidth-1:0]    dr_capture;
   logic [DrWidth-1:0]    dr_shifted;

   logic                  busy;
   logic                  discard;
   logic [1:0]            sticky;
   logic [31:0]           rd_data;

   logic                  rsp_accept;
   logic                  rsp_drop;
   logic                  busy_rsp;
   logic [1:0]            sticky_rsp;
   logic [31:0]           rd_data_rsp;
   logic [1:0]            cap_op;
   logic [31:0]           dtmcs_value;

   logic [1:0]              dr_op;
   logic [31:0]             dr_data;
   logic [AddressWidth-1:0] dr_addr;
   logic                    dr_rw;

   logic                    busy_n;
   logic                    discard_n;
   logic [1:0]              sticky_n;
   logic [31:0]             rd_data_n;
   logic                    valid_n;
   logic [AddressWidth-1:0] addr_n;
   logic [31:0]             data_n;
   logic [1:0]              op_n;

   function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
      case (s)
         TLR:      tap_next = m ? TLR      : RTI;
         RTI:      tap_next = m ? SEL_DR   : RTI;
         SEL_DR:   tap_next = m ? SEL_IR   : CAP_DR;
         CAP_DR:   tap_next = m ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: tap_next = m ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: tap_next = m ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: tap_next = m ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: tap_next = m ? UPD_DR   : SHIFT_DR;
         UPD_DR:   tap_next = m ? SEL_DR   : RTI;
         SEL_IR:   tap_next = m ? TLR      : CAP_IR;
         CAP_IR:   tap_next = m ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: tap_next = m ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: tap_next = m ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: tap_next = m ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: tap_next = m ? UPD_IR   : SHIFT_IR;
         UPD_IR:   tap_next = m ? SEL_DR   : RTI;
         default:  tap_next = TLR;
      endcase
   endfunction

   assign tck_s    = tck_sync[SyncStages-1];
   assign tms_s    = tms_sync[SyncStages-1];
   assign tdi_s    = tdi_sync[SyncStages-1];
   assign tck_rise = tck_s & ~tck_q;
   assign tck_fall = ~tck_s & tck_q;

   assign dmi_rsp_ready = 1'b1;

   // Bring the asynchronous pins into clk and keep one extra tck sample for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tck_sync <= '0;
         tms_sync <= '0;
         tdi_sync <= '0;
         tck_q    <= 1'b0;
      end else begin
         tck_sync <= {tck_sync[SyncStages-2:0], tck};
         tms_sync <= {tms_sync[SyncStages-2:0], tms};
         tdi_sync <= {tdi_sync[SyncStages-2:0], tdi};
         tck_q    <= tck_s;
      end
   end

   // TAP state advances on every synchronized TCK rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap_state <= TLR;
      end else if (tck_rise) begin
         tap_state <= tap_next(tap_state, tms_s);
      end
   end

   // Instruction register: capture, shift and update; Test-Logic-Reset restores IDCODE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir    <= IR_IDCODE;
         ir_sr <= 5'b00001;
      end else if (tap_state == TLR) begin
         ir <= IR_IDCODE;
      end else if (tck_rise) begin
         case (tap_state)
            CAP_IR:   ir_sr <= 5'b00001;
            SHIFT_IR: ir_sr <= {tdi_s, ir_sr[4:1]};
            UPD_IR:   ir    <= ir_sr;
            default:  ;
         endcase
      end
   end

   // Response handling is resolved first so that Capture-DR and DTMCS writes see its effect
   assign rsp_drop    = dmi_rsp_valid & discard & ~dmi_req_valid;
   assign rsp_accept  = dmi_rsp_valid & busy & ~dmi_req_valid & ~discard;
   assign busy_rsp    = busy & ~rsp_accept & ~rsp_drop;
   assign rd_data_rsp = (rsp_accept && dmi_rsp_op == 2'd0) ? dmi_rsp_data : rd_data;
   assign sticky_rsp  = (rsp_accept && dmi_rsp_op[1] && sticky == 2'd0) ? dmi_rsp_op : sticky;
   assign cap_op      = busy_rsp ? 2'd3 : sticky_rsp;
   assign dtmcs_value = {17'd0, 3'(IdleCycles), sticky_rsp, 6'(AddressWidth), 4'd1};

   assign dr_op   = dr_sr[1:0];
   assign dr_data = dr_sr[33:2];
   assign dr_addr = dr_sr[DmiWidth-1:34];
   assign dr_rw   = (dr_op == 2'd1) || (dr_op == 2'd2);

   // Value loaded into the selected data register at Capture-DR
   always_comb begin
      dr_capture = '0;
      unique case (ir)
         IR_IDCODE: dr_capture[31:0]         = IdCode;
         IR_DTMCS:  dr_capture[31:0]         = dtmcs_value;
         IR_DMI:    dr_capture[DmiWidth-1:0] = {dmi_req_addr, rd_data_rsp, cap_op};
         default:   dr_capture               = '0;
      endcase
   end

   // One Shift-DR step: LSB leaves, tdi enters at the MSB of the selected register
   always_comb begin
      dr_shifted = dr_sr >> 1;
      unique case (ir)
         IR_IDCODE, IR_DTMCS: dr_shifted[31]          = tdi_s;
         IR_DMI:              dr_shifted[DmiWidth-1] = tdi_s;
         default:             dr_shifted             = {{(DrWidth-1){1'b0}}, tdi_s};
      endcase
   end

   // Shared data register for IDCODE, DTMCS, DMI and BYPASS
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dr_sr <= '0;
      end else if (tck_rise) begin
         if (tap_state == CAP_DR) begin
            dr_sr <= dr_capture;
         end else if (tap_state == SHIFT_DR) begin
            dr_sr <= dr_shifted;
         end
      end
   end

   // TDO and its enable change on the falling TCK edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tdo    <= 1'b0;
         tdo_oe <= 1'b0;
      end else if (tap_state == TLR) begin
         tdo    <= 1'b0;
         tdo_oe <= 1'b0;
      end else if (tck_fall) begin
         tdo_oe <= (tap_state == SHIFT_IR) || (tap_state == SHIFT_DR);
         tdo    <= (tap_state == SHIFT_IR) ? ir_sr[0] : dr_sr[0];
      end
   end

   // Next state of the DMI initiator: handshake, sticky status and DTMCS resets
   always_comb begin
      busy_n    = busy_rsp;
      discard_n = discard & ~rsp_drop;
      sticky_n  = sticky_rsp;
      rd_data_n = rd_data_rsp;
      valid_n   = dmi_req_valid & ~dmi_req_ready;
      addr_n    = dmi_req_addr;
      data_n    = dmi_req_data;
      op_n      = dmi_req_op;

      if (tck_rise && tap_state == CAP_DR && ir == IR_DMI) begin
         if (busy_rsp && sticky_n == 2'd0) begin
            sticky_n = 2'd3;
         end
      end

      if (tck_rise && tap_state == UPD_DR) begin
         if (ir == IR_DMI && dr_rw) begin
            if (busy_rsp) begin
               if (sticky_n == 2'd0) begin
                  sticky_n = 2'd3;
               end
            end else if (sticky_n == 2'd0) begin
               valid_n = 1'b1;
               busy_n  = 1'b1;
               addr_n  = dr_addr;
               data_n  = dr_data;
               op_n    = dr_op;
            end
         end else if (ir == IR_DTMCS) begin
            if (dr_sr[16] || dr_sr[17]) begin
               sticky_n = 2'd0;
            end
            // A request not yet accepted is withdrawn; an accepted one has its response dropped
            if (dr_sr[17]) begin
               valid_n   = 1'b0;
               busy_n    = 1'b0;
               discard_n = busy_rsp & ~dmi_req_valid;
            end
         end
      end

      // Test-Logic-Reset lets an in-flight transaction finish but forgets its result
      if (tap_state == TLR) begin
         sticky_n  = 2'd0;
         rd_data_n = '0;
         discard_n = discard_n | busy_n;
      end
   end

   // DMI initiator registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy          <= 1'b0;
         discard       <= 1'b0;
         sticky        <= 2'd0;
         rd_data       <= '0;
         dmi_req_valid <= 1'b0;
         dmi_req_addr  <= '0;
         dmi_req_data  <= '0;
         dmi_req_op    <= 2'd0;
      end else begin
         busy          <= busy_n;
         discard       <= discard_n;
         sticky        <= sticky_n;
         rd_data       <= rd_data_n;
         dmi_req_valid <= valid_n;
         dmi_req_addr  <= addr_n;
         dmi_req_data  <= data_n;
         dmi_req_op    <= op_n;
      end
   end

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed testbench for jtag_dtm: drives the JTAG pins slowly relative to clk and
// plays the debug module side of the DMI link.
module tb_jtag_dtm;

   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tck = 1'b0;
   logic        tms = 1'b1;
   logic        tdi = 1'b0;
   logic        tdo;
   logic        tdo_oe;
   logic        dmi_req_valid;
   logic        dmi_req_ready;
   logic [6:0]  dmi_req_addr;
   logic [31:0] dmi_req_data;
   logic [1:0]  dmi_req_op;
   logic        dmi_rsp_valid;
   logic        dmi_rsp_ready;
   logic [31:0] dmi_rsp_data;
   logic [1:0]  dmi_rsp_op;

   int n_checks = 0;
   int n_errors = 0;

   // debug module model configuration (written by the stimulus process only)
   int          stall_cfg    = 0;
   bit          rsp_auto     = 1'b1;
   int          rsp_delay    = 2;
   logic [31:0] rsp_data_cfg = 32'h0;
   logic [1:0]  rsp_op_cfg   = 2'd0;
   int          rsp_kick     = 0;

   // debug module model state (written by the model process only)
   int          kick_seen = 0;
   int          rsp_cnt   = 0;
   int          stall_left = 0;
   bit          prev_vld  = 1'b0;
   int          hs_cnt    = 0;
   int          stall_cnt = 0;
   logic [6:0]  log_addr  = '0;
   logic [31:0] log_data  = '0;
   logic [1:0]  log_op    = '0;

   jtag_dtm #(
      .AddressWidth(7),
      .IdCode(32'h1000_0A6F),
      .SyncStages(2),
      .IdleCycles(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tck(tck),
      .tms(tms),
      .tdi(tdi),
      .tdo(tdo),
      .tdo_oe(tdo_oe),
      .dmi_req_valid(dmi_req_valid),
      .dmi_req_ready(dmi_req_ready),
      .dmi_req_addr(dmi_req_addr),
      .dmi_req_data(dmi_req_data),
      .dmi_req_op(dmi_req_op),
      .dmi_rsp_valid(dmi_rsp_valid),
      .dmi_rsp_ready(dmi_rsp_ready),
      .dmi_rsp_data(dmi_rsp_data),
      .dmi_rsp_op(dmi_rsp_op)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

   // debug module: stalls ready for stall_cfg cycles, answers after rsp_delay cycles or on a kick
   initial begin
      dmi_req_ready = 1'b0;
      dmi_rsp_valid = 1'b0;
      dmi_rsp_data  = '0;
      dmi_rsp_op    = '0;
      forever begin
         @(negedge clk);
         dmi_rsp_valid = 1'b0;
         if (rsp_kick != kick_seen) begin
            kick_seen = rsp_kick;
            rsp_cnt   = 1;
         end
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               dmi_rsp_valid = 1'b1;
               dmi_rsp_data  = rsp_data_cfg;
               dmi_rsp_op    = rsp_op_cfg;
            end
         end
         if (dmi_req_valid) begin
            if (!prev_vld) stall_left = stall_cfg;
            prev_vld = 1'b1;
            if (stall_left > 0) begin
               dmi_req_ready = 1'b0;
               stall_left--;
               stall_cnt++;
            end else begin
               dmi_req_ready = 1'b1;
               hs_cnt++;
               log_addr = dmi_req_addr;
               log_data = dmi_req_data;
               log_op   = dmi_req_op;
               if (rsp_auto) rsp_cnt = rsp_delay;
            end
         end else begin
            dmi_req_ready = 1'b0;
            prev_vld      = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // one TCK period; tdo/tdo_oe are sampled just before the rising edge
   task automatic tck_cycle(input logic m, input logic d, output logic o, output logic e);
      tms = m;
      tdi = d;
      repeat (HALF) @(negedge clk);
      o   = tdo;
      e   = tdo_oe;
      tck = 1'b1;
      repeat (HALF) @(negedge clk);
      tck = 1'b0;
   endtask

   task automatic idle(input int n);
      logic o, e;
      for (int i = 0; i < n; i++) tck_cycle(1'b0, 1'b0, o, e);
   endtask

   // from Run-Test/Idle back to Run-Test/Idle through an IR scan
   task automatic shift_ir(input logic [4:0] v, output logic [4:0] q);
      logic o, e;
      q = '0;
      tck_cycle(1'b1, 1'b0, o, e);
      tck_cycle(1'b1, 1'b0, o, e);
      tck_cycle(1'b0, 1'b0, o, e);
      tck_cycle(1'b0, 1'b0, o, e);
      for (int i = 0; i < 5; i++) begin
         tck_cycle(i == 4, v[i], o, e);
         q[i] = o;
      end
      tck_cycle(1'b1, 1'b0, o, e);
      tck_cycle(1'b0, 1'b0, o, e);
   endtask

   // from Run-Test/Idle back to Run-Test/Idle through an n-bit DR scan
   task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                           output logic oe_on, output logic oe_after);
      logic o, e;
      dout  = '0;
      oe_on = 1'b1;
      tck_cycle(1'b1, 1'b0, o, e);
      tck_cycle(1'b0, 1'b0, o, e);
      tck_cycle(1'b0, 1'b0, o, e);
      for (int i = 0; i < n; i++) begin
         tck_cycle(i == n - 1, din[i], o, e);
         dout[i] = o;
         oe_on   = oe_on & e;
      end
      tck_cycle(1'b1, 1'b0, o, e);
      oe_after = e;
      tck_cycle(1'b0, 1'b0, o, e);
   endtask

   function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
      return {23'd0, a, d, op};
   endfunction

   initial begin
      logic [4:0]  irq;
      logic [63:0] q;
      logic        oe_on, oe_after, o, e;
      int          hs0, st0;

      repeat (5) @(negedge clk);
      check("reset_tdo", tdo, 0);
      check("reset_tdo_oe", tdo_oe, 0);
      check("reset_req_valid", dmi_req_valid, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // IDCODE selected out of reset
      idle(1);
      shift_dr(32, 64'h0, q, oe_on, oe_after);
      check("idcode", q, 64'h1000_0A6F);
      check("idcode_oe_during_shift", oe_on, 1);
      check("idcode_oe_after_shift", oe_after, 0);
      check("oe_idle", tdo_oe, 0);

      // DTMCS after reset
      shift_ir(5'h10, irq);
      check("ir_capture", irq, 5'b00001);
      shift_dr(32, 64'h0, q, oe_on, oe_after);
      check("dtmcs_reset", q, 64'h0000_1071);

      // DMI write with a stalled debug module
      shift_ir(5'h11, irq);
      stall_cfg = 3; rsp_auto = 1'b1; rsp_delay = 2; rsp_data_cfg = 32'h0000_5A5A; rsp_op_cfg = 2'd0;
      hs0 = hs_cnt; st0 = stall_cnt;
      shift_dr(41, dmi(7'h10, 32'h1, 2'd2), q, oe_on, oe_after);
      check("dmi_first_capture", q, 64'h0);
      check("dmi_oe_during_shift", oe_on, 1);
      idle(2);
      check("wr_handshakes", hs_cnt - hs0, 1);
      check("wr_stall_cycles", stall_cnt - st0, 3);
      check("wr_addr", log_addr, 7'h10);
      check("wr_data", log_data, 32'h1);
      check("wr_op", log_op, 2'd2);
      check("wr_valid_dropped", dmi_req_valid, 0);

      // DMI read; the write response data was captured
      stall_cfg = 0; rsp_data_cfg = 32'hDEAD_BEEF;
      shift_dr(41, dmi(7'h11, 32'h0, 2'd1), q, oe_on, oe_after);
      check("rd_capture_after_write", q, dmi(7'h10, 32'h0000_5A5A, 2'd0));
      idle(2);
      check("rd_addr", log_addr, 7'h11);
      check("rd_op", log_op, 2'd1);
      shift_dr(41, 64'h0, q, oe_on, oe_after);
      check("rd_result", q, dmi(7'h11, 32'hDEAD_BEEF, 2'd0));

      // busy: response withheld, second update must not issue
      rsp_auto = 1'b0;
      hs0 = hs_cnt;
      shift_dr(41, dmi(7'h12, 32'h0, 2'd1), q, oe_on, oe_after);
      check("busy_first_capture", q, dmi(7'h11, 32'hDEAD_BEEF, 2'd0));
      idle(2);
      shift_dr(41, dmi(7'h13, 32'h77, 2'd2), q, oe_on, oe_after);
      check("busy_capture_op3", q, dmi(7'h12, 32'hDEAD_BEEF, 2'd3));
      idle(2);
      check("busy_no_new_request", hs_cnt - hs0, 1);
      rsp_data_cfg = 32'h0000_1234; rsp_op_cfg = 2'd0;
      rsp_kick++;
      idle(2);
      shift_dr(41, 64'h0, q, oe_on, oe_after);
      check("busy_sticky_held", q, dmi(7'h12, 32'h0000_1234, 2'd3));
      shift_ir(5'h10, irq);
      shift_dr(32, 64'h0001_0000, q, oe_on, oe_after);
      check("dtmcs_sticky3", q, 64'h0000_1C71);
      shift_ir(5'h11, irq);
      shift_dr(41, 64'h0, q, oe_on, oe_after);
      check("dmireset_clears", q, dmi(7'h12, 32'h0000_1234, 2'd0));

      // failed read response
      rsp_auto = 1'b1; rsp_data_cfg = 32'hFFFF_FFFF; rsp_op_cfg = 2'd2;
      shift_dr(41, dmi(7'h14, 32'h0, 2'd1), q, oe_on, oe_after);
      idle(2);
      hs0 = hs_cnt;
      shift_dr(41, 64'h0, q, oe_on, oe_after);
      check("rsp_failed_op2", q, dmi(7'h14, 32'h0000_1234, 2'd2));
      shift_dr(41, dmi(7'h15, 32'h0, 2'd1), q, oe_on, oe_after);
      idle(2);
      check("sticky_blocks_issue", hs_cnt - hs0, 0);
      shift_ir(5'h10, irq);
      shift_dr(32, 64'h0001_0000, q, oe_on, oe_after);
      check("dtmcs_sticky2", q, 64'h0000_1871);

      // dmihardreset with a request still waiting for ready
      stall_cfg = 1000; rsp_op_cfg = 2'd3; rsp_data_cfg = 32'hBAD0_BAD0;
      shift_ir(5'h11, irq);
      shift_dr(41, dmi(7'h15, 32'h0000_CAFE, 2'd2), q, oe_on, oe_after);
      check("hardreset_pending", dmi_req_valid, 1);
      shift_ir(5'h10, irq);
      shift_dr(32, 64'h0002_0000, q, oe_on, oe_after);
      check("hardreset_drops_valid", dmi_req_valid, 0);
      rsp_kick++;
      idle(2);
      shift_ir(5'h11, irq);
      shift_dr(41, 64'h0, q, oe_on, oe_after);
      check("late_rsp_ignored", q, dmi(7'h15, 32'h0000_1234, 2'd0));

      // link usable again after dmihardreset
      stall_cfg = 0; rsp_op_cfg = 2'd0; rsp_data_cfg = 32'h0BAD_F00D;
      shift_dr(41, dmi(7'h16, 32'h0, 2'd1), q, oe_on, oe_after);
      idle(2);
      shift_dr(41, 64'h0, q, oe_on, oe_after);
      check("post_hardreset_read", q, dmi(7'h16, 32'h0BAD_F00D, 2'd0));

      // BYPASS: tdi 1,0,1,1 comes back one TCK later
      shift_ir(5'h1F, irq);
      shift_dr(4, 64'b1101, q, oe_on, oe_after);
      check("bypass", q, 64'b1010);

      // five tms=1 from Shift-DR reach Test-Logic-Reset and reselect IDCODE
      shift_ir(5'h10, irq);
      tck_cycle(1'b1, 1'b0, o, e);
      tck_cycle(1'b0, 1'b0, o, e);
      tck_cycle(1'b0, 1'b0, o, e);
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, o, e);
      tck_cycle(1'b0, 1'b0, o, e);
      check("tlr_oe", e, 0);
      shift_dr(32, 64'h0, q, oe_on, oe_after);
      check("tlr_idcode", q, 64'h1000_0A6F);

      // asynchronous reset in the middle of a stalled request
      stall_cfg = 1000;
      shift_ir(5'h11, irq);
      shift_dr(41, dmi(7'h17, 32'h1, 2'd2), q, oe_on, oe_after);
      check("rst_req_pending", dmi_req_valid, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_async_valid", dmi_req_valid, 0);
      check("rst_async_oe", tdo_oe, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      idle(1);
      shift_ir(5'h11, irq);
      shift_dr(41, 64'h0, q, oe_on, oe_after);
      check("rst_dmi_cleared", q, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
